// File: rtl/spi_master_ctrl_if.sv
// SPI master controller bus: system handshake plus SPI pins.
// The controller takes the master modport, the far side the slave modport.
interface spi_master_ctrl_if #(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 2,
  parameter int IDX_W      = 1
);
  logic                  start;
  logic [DATA_W-1:0]     tx_data;
  logic [IDX_W-1:0]      slave_idx;
  logic                  ready;
  logic [DATA_W-1:0]     rx_data;
  logic                  rx_valid;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic [NUM_SLAVES-1:0] ss_n;

  modport master (
    input  start, tx_data, slave_idx, miso,
    output ready, rx_data, rx_valid, sclk, mosi, ss_n
  );

  modport slave (
    output start, tx_data, slave_idx, miso,
    input  ready, rx_data, rx_valid, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one MSB-first byte per transfer,
// divided SCLK, one active-low select per slave.
module spi_master_ctrl #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 4,
  parameter int NUM_SLAVES = 2,
  parameter int IDX_W      = 1
) (
  input  logic clk,
  input  logic rst,
  spi_master_ctrl_if.master bus
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_W-1:0]     r_tx;
  logic [DATA_W-1:0]     r_rx;
  logic [DATA_W-1:0]     r_rx_data;
  logic                  r_sclk;
  logic                  r_mosi;
  logic [NUM_SLAVES-1:0] r_ss_n;

  logic w_tick;
  logic w_idx_ok;
  logic w_last;
  logic w_accept;
  logic w_rise;
  logic w_fall;

  assign w_tick   = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_last   = (r_bit == BIT_W'(DATA_W - 1));
  assign w_idx_ok = ({1'b0, bus.slave_idx} < (IDX_W+1)'(NUM_SLAVES));

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_rise   = 1'b0;
    w_fall   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start && w_idx_ok) begin
          w_accept = 1'b1;
          w_next   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_tick) begin
          w_rise = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_tick) begin
          if (!r_sclk) begin
            w_rise = 1'b1;
          end else begin
            w_fall = 1'b1;
            if (w_last) w_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_tick) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss_n    <= '1;
    end else begin
      // divider only runs while a transfer owns the bus
      if (w_tick || r_state == S_IDLE || r_state == S_DONE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        r_tx   <= bus.tx_data << 1;
        r_mosi <= bus.tx_data[DATA_W-1];
        r_ss_n <= ~(NUM_SLAVES'(1) << bus.slave_idx);
        r_bit  <= '0;
        r_rx   <= '0;
      end

      if (w_rise) begin
        r_sclk <= 1'b1;
        r_rx   <= (r_rx << 1) | DATA_W'(bus.miso);
      end

      if (w_fall) begin
        r_sclk <= 1'b0;
        if (w_last) begin
          r_mosi <= 1'b0;
        end else begin
          r_mosi <= r_tx[DATA_W-1];
          r_tx   <= r_tx << 1;
          r_bit  <= r_bit + 1'b1;
        end
      end

      if (r_state == S_HOLD && w_tick) begin
        r_ss_n    <= '1;
        r_rx_data <= r_rx;
      end
    end
  end

  assign bus.ready    = (r_state == S_IDLE);
  assign bus.rx_valid = (r_state == S_DONE);
  assign bus.rx_data  = r_rx_data;
  assign bus.sclk     = r_sclk;
  assign bus.mosi     = r_mosi;
  assign bus.ss_n     = r_ss_n;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: vector table, random transfers
// against a mode-0 slave model, and reset/timing corner cases.
module tb_spi_master_ctrl;
  localparam int L0 = 17 * 4;
  localparam int L1 = 17 * 2;
  localparam int L2 = 17 * 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.DATA_W(8), .NUM_SLAVES(2), .IDX_W(1)) b0();
  spi_master_ctrl_if #(.DATA_W(8), .NUM_SLAVES(1), .IDX_W(1)) b1();
  spi_master_ctrl_if #(.DATA_W(8), .NUM_SLAVES(2), .IDX_W(1)) b2();

  spi_master_ctrl #(
    .DATA_W(8), .CLK_DIV(4), .NUM_SLAVES(2), .IDX_W(1)
  ) dut0 (.clk(clk), .rst(rst), .bus(b0.master));

  spi_master_ctrl #(
    .DATA_W(8), .CLK_DIV(2), .NUM_SLAVES(1), .IDX_W(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(b1.master));

  spi_master_ctrl #(
    .DATA_W(8), .CLK_DIV(1), .NUM_SLAVES(2), .IDX_W(1)
  ) dut2 (.clk(clk), .rst(rst), .bus(b2.master));

  int tests = 0;
  int fails = 0;
  int inv_bad = 0;

  logic       loop0 = 1'b0;
  logic       s_miso = 1'b0;
  logic [7:0] s_resp = 8'h00;
  logic [7:0] s_rx = 8'h00;
  int         s_bit = 0;
  int         s_rises = 0;
  logic [1:0] s_prev_ss = 2'b11;
  logic       s_prev_sclk = 1'b0;

  assign b0.miso = loop0 ? b0.mosi : s_miso;
  assign b1.miso = b1.mosi;
  assign b2.miso = b2.mosi;

  // mode-0 slave: presents MSB on select, next bit after each SCLK fall
  always @(negedge clk) begin
    s_prev_ss   <= b0.ss_n;
    s_prev_sclk <= b0.sclk;
    if (&b0.ss_n) begin
      s_miso <= 1'b0;
    end else if (&s_prev_ss) begin
      s_miso  <= s_resp[7];
      s_bit   <= 1;
      s_rx    <= 8'h00;
      s_rises <= 0;
    end else begin
      if (b0.sclk && !s_prev_sclk) begin
        s_rx    <= {s_rx[6:0], b0.mosi};
        s_rises <= s_rises + 1;
      end
      if (!b0.sclk && s_prev_sclk && s_bit < 8) begin
        s_miso <= s_resp[3'(7 - s_bit)];
        s_bit  <= s_bit + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if ((b0.sclk && &b0.ss_n) || b0.ss_n == 2'b00)
        inv_bad <= inv_bad + 1;
      if ((b2.sclk && &b2.ss_n) || b2.ss_n == 2'b00)
        inv_bad <= inv_bad + 1;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", nm, act, exp);
    end
  endtask

  // called at a negedge; accept happens at the next edge (edge N)
  task automatic run0(input logic [7:0] tx, input logic idx,
                      input logic [7:0] resp, input logic lp,
                      input logic hold, input int pulse_c,
                      input logic [7:0] exp);
    int vcnt;
    int vcyc;
    int low;
    logic [7:0] got;
    logic [1:0] pat;
    logic endok;
    vcnt = 0;
    vcyc = -1;
    low = 0;
    got = 8'h00;
    endok = 1'b0;
    pat = idx ? 2'b01 : 2'b10;
    s_resp = resp;
    loop0 = lp;
    b0.start = 1'b1;
    b0.tx_data = tx;
    b0.slave_idx = idx;
    @(negedge clk);
    for (int c = 0; c <= L0 + 1; c++) begin
      if (!hold) b0.start = (c == pulse_c);
      b0.tx_data = 8'($urandom);
      b0.slave_idx = 1'($urandom);
      if (b0.rx_valid) begin
        vcnt++;
        vcyc = c;
        got = b0.rx_data;
      end
      if (b0.ss_n == pat) low++;
      if (c == L0 + 1) endok = b0.ready && (b0.ss_n == 2'b11);
      if (c <= L0) @(negedge clk);
    end
    chk("rxv_count", 32'(vcnt), 32'd1);
    chk("rxv_cycle", 32'(vcyc), 32'(L0));
    chk("rx_data", 32'(got), 32'(exp));
    chk("ss_low_cycles", 32'(low), 32'(L0));
    chk("end_idle", 32'(endok), 32'd1);
    chk("slave_rx", 32'(s_rx), 32'(tx));
    chk("sclk_rises", 32'(s_rises), 32'd8);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       idx;
    logic [7:0] resp;
    logic       lp;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int v;
    int bad;
    int vcyc;
    logic [7:0] got;
    logic [7:0] tx;
    logic [7:0] resp;
    logic idx;
    logic lp;

    tbl[0] = '{8'hA5, 1'b0, 8'h00, 1'b1, 8'hA5};
    tbl[1] = '{8'hFF, 1'b1, 8'h3C, 1'b0, 8'h3C};
    tbl[2] = '{8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF};
    tbl[3] = '{8'h81, 1'b1, 8'h00, 1'b1, 8'h81};
    tbl[4] = '{8'h5A, 1'b0, 8'hA6, 1'b0, 8'hA6};

    b0.start = 1'b0; b0.tx_data = 8'h00; b0.slave_idx = 1'b0;
    b1.start = 1'b0; b1.tx_data = 8'h00; b1.slave_idx = 1'b0;
    b2.start = 1'b0; b2.tx_data = 8'h00; b2.slave_idx = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs",
        32'({b0.ready, b0.ss_n, b0.sclk, b0.mosi,
             b0.rx_valid, b0.rx_data}),
        32'({1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00}));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run0(tbl[i].tx, tbl[i].idx, tbl[i].resp,
           tbl[i].lp, 1'b0, -1, tbl[i].exp);

    // back-to-back with start held high through the first transfer
    run0(8'h12, 1'b0, 8'h00, 1'b1, 1'b1, -1, 8'h12);
    run0(8'h34, 1'b0, 8'h00, 1'b1, 1'b0, -1, 8'h34);

    for (int i = 0; i < 10; i++) begin
      tx   = 8'($urandom);
      resp = 8'($urandom);
      idx  = 1'($urandom_range(0, 1));
      lp   = 1'($urandom_range(0, 1));
      run0(tx, idx, resp, lp, 1'b0,
           int'($urandom_range(2, L0 - 1)), lp ? tx : resp);
    end

    // reset landing at edge N+30
    b0.start = 1'b1; b0.tx_data = 8'hC7; b0.slave_idx = 1'b0;
    loop0 = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (29) @(negedge clk);
    chk("pre_rst_busy", 32'(b0.ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs",
        32'({b0.ready, b0.ss_n, b0.sclk, b0.mosi,
             b0.rx_valid, b0.rx_data}),
        32'({1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00}));
    rst = 1'b0;
    v = 0;
    repeat (80) begin
      @(negedge clk);
      if (b0.rx_valid) v++;
    end
    chk("midrst_no_rxv", 32'(v), 32'd0);
    run0(8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, -1, 8'h5A);

    // single-slave instance: out-of-range index must be ignored
    bad = 0;
    b1.start = 1'b1; b1.slave_idx = 1'b1; b1.tx_data = 8'hE7;
    repeat (4) begin
      @(negedge clk);
      if (!b1.ready || b1.ss_n !== 1'b1 || b1.sclk || b1.mosi) bad++;
    end
    chk("oor_ignored", 32'(bad), 32'd0);
    b1.slave_idx = 1'b0; b1.tx_data = 8'hC3;
    @(negedge clk);
    b1.start = 1'b0;
    vcyc = -1; got = 8'h00;
    for (int c = 0; c <= L1 + 1; c++) begin
      if (b1.rx_valid) begin vcyc = c; got = b1.rx_data; end
      if (c <= L1) @(negedge clk);
    end
    chk("d1_rxv_cycle", 32'(vcyc), 32'(L1));
    chk("d1_rx", 32'(got), 32'h0000_00C3);

    // CLK_DIV=1: SCLK is clk/2
    bad = 0;
    b2.start = 1'b1; b2.slave_idx = 1'b0; b2.tx_data = 8'h81;
    @(negedge clk);
    b2.start = 1'b0;
    vcyc = -1; got = 8'h00;
    for (int c = 0; c <= L2 + 1; c++) begin
      if (c <= 16 && b2.sclk !== 1'(c % 2)) bad++;
      if (b2.rx_valid) begin vcyc = c; got = b2.rx_data; end
      if (c <= L2) @(negedge clk);
    end
    chk("d2_sclk_period", 32'(bad), 32'd0);
    chk("d2_rxv_cycle", 32'(vcyc), 32'(L2));
    chk("d2_rx", 32'(got), 32'h0000_0081);

    @(negedge clk);
    chk("invariants", 32'(inv_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master controller that drives the team's SPI slave blocks: it generates SCLK and active-low per-slave selects, shifts a parallel byte out on MOSI, and collects the slave's MISO byte.
- Sits between the system-side command logic (start/ready/rx_valid handshake) and the SPI pins routed to the slave instances.
- Mode 0 only (CPOL=0, CPHA=0), MSB first, one byte per transfer.

Parameters:
- DATA_W, 8, bits per transfer.
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range ≥1.
- NUM_SLAVES, 2, number of select lines; legal range ≥1.
- IDX_W, 1, width of slave_idx; must satisfy 2^IDX_W ≥ NUM_SLAVES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  transfer request; sampled only when ready=1.
- tx_data  input  DATA_W  byte to transmit; latched on accept.
- slave_idx  input  IDX_W  target slave; latched on accept.
- ready  output  1  controller idle and able to accept start.
- rx_data  output  DATA_W  byte received on MISO; holds until the next transfer completes.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- sclk  output  1  SPI clock, idles low.
- mosi  output  1  serial data to slave.
- miso  input  1  serial data from slave.
- ss_n  output  NUM_SLAVES  active-low selects; at most one low at any time.

Behaviour:
- Reset: while rst=1 at a clk edge, outputs take these values: state=IDLE, ss_n all 1, sclk=0, mosi=0, rx_data=0, rx_valid=0, ready=1; internal counters cleared.
- Reset applied mid-transfer aborts the transfer in one cycle with the same values. No rx_valid pulse is produced.

States:
- IDLE, SETUP, SHIFT, HOLD, DONE.

Accept:
- Occurs at edge N when state=IDLE, start=1 and slave_idx < NUM_SLAVES.
- tx_data and slave_idx are latched.
- ss_n[slave_idx] goes to 0, mosi = tx_data[DATA_W-1], ready goes to 0, state goes to SETUP.

Out-of-range index:
- start with slave_idx ≥ NUM_SLAVES is ignored: ready stays 1 and no pins change.

start while not IDLE:
- Ignored. tx_data and slave_idx changes after accept have no effect.

SETUP:
- Lasts CLK_DIV cycles with sclk=0.
- At edge N+CLK_DIV, sclk goes to 1 and state goes to SHIFT.

SHIFT:
- sclk toggles every CLK_DIV cycles.
- Rising edges occur at edges N+CLK_DIV·(2k+1), for k = 0..DATA_W-1.
- At each rising edge, miso (the value present in the preceding cycle) is shifted into the receive register at the LSB end.
- Falling edges occur at edges N+CLK_DIV·(2k+2).
- At falling edges k = 0..DATA_W-2, mosi advances to the next bit: tx_data[DATA_W-2-k].
- At the final falling edge (N+2·DATA_W·CLK_DIV), mosi goes to 0 and state goes to HOLD.
- Exactly DATA_W rising edges occur per transfer.

HOLD:
- sclk=0, select still asserted, for CLK_DIV cycles.

DONE entry:
- Occurs at edge N+(2·DATA_W+1)·CLK_DIV.
- ss_n goes to all 1, rx_data is loaded with the receive register, rx_valid goes to 1.

DONE to IDLE:
- Next edge: rx_valid goes to 0, ready goes to 1, state goes to IDLE.
- A start present in this IDLE cycle is accepted at the following edge; back-to-back transfers have ss_n high for ≥1 cycle between them.

Latency and timing rules:
- With the defaults (DATA_W=8, CLK_DIV=4), rx_valid is high in the cycle following edge N+68.
- The clock divider counter wraps from CLK_DIV-1 to 0.
- CLK_DIV=1 gives sclk = clk/2 with the same edge formulas.
- Invariant: sclk=1 only while some ss_n bit is 0.

Test Plan:
- Loopback (miso tied to mosi), CLK_DIV=4, slave_idx=0, tx_data=0xA5:
  - ss_n=2'b10 from edge N to N+68.
  - 8 sclk rising edges observed.
  - rx_valid for exactly one cycle after edge N+68, rx_data=0xA5.
  - ready=1 after edge N+69.
- Behavioural slave model on idx 1 returning 0x3C, tx_data=0xFF:
  - mosi holds 1 on all 8 rising edges.
  - rx_data=0x3C.
  - ss_n=2'b01 during the transfer; ss_n[0] never low.
- Back-to-back transfers 0x12 then 0x34, with start held high:
  - Two rx_valid pulses.
  - ss_n high for ≥1 cycle between transfers.
  - Second tx_data unaffected by changes to tx_data during the first transfer.
- Reset asserted at edge N+30 of a transfer:
  - Next cycle: ss_n=2'b11, sclk=0, mosi=0, ready=1, rx_data=0.
  - No rx_valid pulse.
  - A new transfer of 0x5A then completes correctly.
- start with slave_idx=1 while NUM_SLAVES=1 (out of range), and start pulsed mid-transfer:
  - Both ignored: no pin activity, ready unaffected, current transfer completes unchanged.
- CLK_DIV=1, loopback, tx_data=0x81:
  - rx_valid after edge N+17, rx_data=0x81.
  - sclk period 2 clk cycles.
